program_memory: RTL
===================

# program_memory

Parametrised instruction store for the MIPS IF stage, the next generation of the loader memory. A streaming valid/ready write port fills it word by word until a HALT word or capacity is reached. It then serves byte-addressed PC reads with one-cycle registered latency. It guards fetches against misaligned and unloaded addresses, and supports a synchronous flush-and-reload without a global reset.

## Interface
- WORD_SIZE_IN_BYTES, 4, instruction width in bytes; W = 8*WORD_SIZE_IN_BYTES bits.
- MEM_SIZE_IN_WORDS, 64, capacity in words; must be ≥2.
- PC_WIDTH, 32, width of the byte-address PC input.
- HALT_WORD, 32'hFFFF_FFFF, W-bit halt encoding; also returned on any guarded fetch.
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_flush  in  1  synchronous clear: empties memory, returns to LOAD.
- i_wr_valid  in  1  write word offered.
- i_wr_data  in  W  instruction word to append.
- o_wr_ready  out  1  write port accepts; = (state==LOAD) && !full && !i_flush.
- i_rd_en  in  1  fetch request.
- i_pc  in  PC_WIDTH  byte address of fetch.
- o_instruction  out  W  registered fetched word.
- o_misaligned  out  1  registered; last fetch had i_pc[log2(WORD_SIZE_IN_BYTES)-1:0] ≠ 0.
- o_out_of_range  out  1  registered; last fetch word index ≥ o_count.
- o_loaded  out  1  state==RUN.
- o_full  out  1  o_count == MEM_SIZE_IN_WORDS.
- o_empty  out  1  o_count == 0.
- o_count  out  $clog2(MEM_SIZE_IN_WORDS+1)  words stored.

## Operation
- States: LOAD (reset state), RUN.
- LOAD: on a rising edge with i_wr_valid && o_wr_ready:
  - mem[o_count] <= i_wr_data; o_count++.
  - If i_wr_data == HALT_WORD, go to RUN (the HALT word is stored and counted).
  - Else if o_count becomes MEM_SIZE_IN_WORDS, go to RUN (auto-terminate when full).
- RUN: the write port is closed (o_wr_ready=0) and writes are ignored. A fetch is accepted on a rising edge with i_rd_en:
  - word index = i_pc >> log2(WORD_SIZE_IN_BYTES); any upper bits are included in the range check.
  - Misaligned: o_instruction <= HALT_WORD, o_misaligned <= 1, o_out_of_range <= (index ≥ o_count).
  - Else if index ≥ o_count: o_instruction <= HALT_WORD, o_out_of_range <= 1, o_misaligned <= 0.
  - Else: o_instruction <= mem[index], both flags <= 0.
- i_rd_en low, or any cycle in LOAD: o_instruction and both flags hold.
- i_flush (any state): o_count <= 0, state <= LOAD, o_instruction <= 0, flags <= 0. Memory contents need not be cleared; unloaded words are never returned.
- Priority: i_reset > i_flush > write/fetch. A write presented in the same cycle as i_flush is not accepted (o_wr_ready=0).
- Memory array is not reset. All other state is reset.

## Timing
- Reset values: state LOAD, o_count 0, o_instruction 0, o_misaligned 0, o_out_of_range 0, o_loaded 0, o_full 0, o_empty 1, o_wr_ready 1.
- Write: one word per cycle sustained. o_count, o_empty, o_full and o_loaded update on the accepting edge.
- The last write (HALT or capacity) flips o_loaded at that edge. A fetch is accepted from the next edge on.
- Fetch latency 1 cycle: i_pc sampled at edge N, data valid after edge N, one fetch per cycle.
- Reset asserted mid-load or mid-run: immediate return to reset values; a stream in progress is discarded.
- o_wr_ready is combinational from state, o_count and i_flush only. It has no path from i_wr_valid.

## Test plan
- Reset, stream 0x20010005, 0x20020003, 0xFFFFFFFF with valid held high -> o_count 3, o_loaded 1 after the 3rd edge, o_wr_ready 0. Fetch pc 0, 4, 8 -> 0x20010005, 0x20020003, 0xFFFFFFFF at one cycle each.
- MEM_SIZE_IN_WORDS=4: stream 5 non-HALT words -> 4 accepted, o_full 1, o_loaded 1, 5th not accepted. Fetch pc 12 -> 4th word.
- After a 3-word load: fetch pc 6 -> HALT_WORD, o_misaligned 1. Fetch pc 12 -> HALT_WORD, o_out_of_range 1. Fetch pc 4 -> stored word, both flags 0.
- Toggle i_wr_valid randomly during load -> words stored in order with no gaps. Fetch readback matches exactly.
- In RUN: assert i_flush together with i_wr_valid -> o_count 0, o_loaded 0, o_instruction 0, write not taken. Reload of 2 words then succeeds and fetch returns the new data.
- Assert i_reset asynchronously mid-stream after 2 words -> outputs immediately at reset values. Fetch after a fresh 1-word HALT load, pc 0 -> 0xFFFFFFFF, o_out_of_range 0.

Source files
------------

// File: rtl/program_memory.sv
// Instruction store for the IF stage: streamed in word by word, then read by byte-addressed PC.
// Latency: writes land on the accepting edge; fetch data, misaligned and range flags are valid one cycle after i_rd_en is sampled.
// Backpressure: o_wr_ready drops once loaded, when full, or during i_flush; the fetch side never stalls.
//
// Ports:
//   i_clk, i_reset        rising-edge clock, asynchronous active-high reset
//   i_flush               synchronous clear back to LOAD (memory contents are kept but become unreachable)
//   i_wr_valid/i_wr_data  streaming write port, handshaked with o_wr_ready
//   i_rd_en, i_pc         fetch request with a byte-address PC
//   o_instruction         registered fetched word (HALT_WORD on a guarded fetch)
//   o_misaligned          registered: last accepted fetch had nonzero byte-offset bits
//   o_out_of_range        registered: last accepted fetch word index >= o_count
//   o_loaded, o_full, o_empty, o_count   load status
module program_memory #(
  parameter int WORD_SIZE_IN_BYTES = 4,
  parameter int MEM_SIZE_IN_WORDS  = 64,   // must be >= 2
  parameter int PC_WIDTH           = 32,
  parameter logic [8*WORD_SIZE_IN_BYTES-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                                   i_clk,
  input  logic                                   i_reset,
  input  logic                                   i_flush,
  input  logic                                   i_wr_valid,
  input  logic [8*WORD_SIZE_IN_BYTES-1:0]        i_wr_data,
  output logic                                   o_wr_ready,
  input  logic                                   i_rd_en,
  input  logic [PC_WIDTH-1:0]                    i_pc,
  output logic [8*WORD_SIZE_IN_BYTES-1:0]        o_instruction,
  output logic                                   o_misaligned,
  output logic                                   o_out_of_range,
  output logic                                   o_loaded,
  output logic                                   o_full,
  output logic                                   o_empty,
  output logic [$clog2(MEM_SIZE_IN_WORDS+1)-1:0] o_count
);

  localparam int W    = 8 * WORD_SIZE_IN_BYTES;
  localparam int OFFS = $clog2(WORD_SIZE_IN_BYTES);
  localparam int CW   = $clog2(MEM_SIZE_IN_WORDS + 1);
  localparam int AW   = $clog2(MEM_SIZE_IN_WORDS);
  // Common width for the index-vs-count compare so no upper PC bit is lost.
  localparam int XW   = (PC_WIDTH > CW) ? PC_WIDTH : CW;

  localparam logic [CW-1:0]       CAPACITY  = CW'(MEM_SIZE_IN_WORDS);
  // Byte-offset mask; all zero for single-byte words, so nothing is ever misaligned.
  localparam logic [PC_WIDTH-1:0] OFFS_MASK = PC_WIDTH'(WORD_SIZE_IN_BYTES - 1);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  // Storage has no reset; o_count alone decides which words are reachable.
  logic [W-1:0] mem [MEM_SIZE_IN_WORDS];

  logic          wr_fire;
  logic          wr_last;
  logic [CW-1:0] count_inc;

  logic [PC_WIDTH-1:0] word_idx;
  logic [AW-1:0]       rd_addr;
  logic                fetch_fire;
  logic                fetch_mis;
  logic                fetch_oor;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  assign wr_fire   = i_wr_valid && o_wr_ready;
  assign count_inc = o_count + CW'(1);
  // HALT is stored and counted; filling the last slot also terminates the load.
  assign wr_last   = wr_fire && ((i_wr_data == HALT_WORD) || (count_inc == CAPACITY));

  always_ff @(posedge i_clk) begin
    if (wr_fire) begin
      mem[o_count[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_count <= '0;
    end else if (i_flush) begin
      o_count <= '0;
    end else if (wr_fire) begin
      o_count <= count_inc;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: if (wr_last) state_d = ST_RUN;
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_LOAD;
      endcase
    end
  end

  // FSM: outputs. o_wr_ready deliberately depends only on state, count and
  // flush so an upstream valid can never loop back into its own ready.
  always_comb begin
    o_loaded   = (state_q == ST_RUN);
    o_full     = (o_count == CAPACITY);
    o_empty    = (o_count == '0);
    o_wr_ready = (state_q == ST_LOAD) && !o_full && !i_flush;
  end

  // ---------------------------------------------------------------------------
  // Fetch side
  // ---------------------------------------------------------------------------
  assign word_idx   = i_pc >> OFFS;
  // Only used when the index is below o_count, so the low bits are the full index.
  assign rd_addr    = word_idx[AW-1:0];
  assign fetch_fire = (state_q == ST_RUN) && i_rd_en;
  assign fetch_mis  = |(i_pc & OFFS_MASK);
  assign fetch_oor  = (XW'(word_idx) >= XW'(o_count));

  // Guarded fetches return HALT_WORD so a runaway PC stops the core cleanly
  // instead of executing stale memory. Misaligned still reports the range flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_instruction  <= '0;
      o_misaligned   <= 1'b0;
      o_out_of_range <= 1'b0;
    end else if (i_flush) begin
      o_instruction  <= '0;
      o_misaligned   <= 1'b0;
      o_out_of_range <= 1'b0;
    end else if (fetch_fire) begin
      o_misaligned   <= fetch_mis;
      o_out_of_range <= fetch_oor;
      if (fetch_mis || fetch_oor) begin
        o_instruction <= HALT_WORD;
      end else begin
        o_instruction <= mem[rd_addr];
      end
    end
  end

endmodule
